palette_ctl: RTL

Sequencer and arbiter for the 16x8 single-port palette RAM (BBGGGRRR colour entries).
- After reset, loads a default palette into the RAM.
- Serves per-pixel colour lookups from the video pipeline; video always has priority.
- Buffers CPU palette writes (OUT 0Ch path) in a small queue and retires them in cycles the video does not use.
- Sits between the I/O decoder, the pixel serialiser and the RAM primitive.

---
 rtl/palette_ctl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/palette_ctl.sv
`default_nettype none
// ============================================================================
// Module      : palette_ctl
// Description : Sequencer and arbiter for the 16x8 single-port palette RAM.
//               Loads a default palette after reset, serves pipelined video
//               colour lookups with top priority, and buffers CPU palette
//               writes in a small FIFO that drains in video-idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module palette_ctl #(
  parameter int WQ_DEPTH = 4,
  parameter int WQ_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vid_req,
  input  logic [3:0] vid_idx,
  output logic [7:0] vid_color,
  output logic       vid_valid,
  input  logic       cpu_wr,
  input  logic [3:0] cpu_idx,
  input  logic [7:0] cpu_data,
  output logic       cpu_busy,
  output logic       wr_drop,
  output logic       init_done,
  output logic       ram_ce,
  output logic       ram_oce,
  output logic       ram_reset,
  output logic       ram_wre,
  output logic [3:0] ram_ad,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  localparam logic [WQ_AW:0] c_depth = (WQ_AW + 1)'(WQ_DEPTH);
  localparam logic [3:0]     c_last  = 4'd15;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_init_cnt;
  logic [3:0]        w_init_cnt_nxt;

  // Write queue storage: {index, colour}
  logic [11:0]       r_wq_mem [WQ_DEPTH];
  logic [WQ_AW-1:0]  r_wq_rd_ptr;
  logic [WQ_AW-1:0]  r_wq_wr_ptr;
  logic [WQ_AW:0]    r_wq_count;
  logic [11:0]       w_wq_head;
  logic              w_wq_full;
  logic              w_wq_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_issue;

  logic              r_rd_p1;
  logic              r_vid_valid;
  logic [7:0]        r_vid_color;
  logic              r_wr_drop;

  assign w_wq_head  = r_wq_mem[r_wq_rd_ptr];
  assign w_wq_full  = (r_wq_count == c_depth);
  assign w_wq_empty = (r_wq_count == '0);

  // Arbitration: video read beats queued write; nothing is served during INIT
  assign w_rd_issue = !reset && (r_state == ST_RUN) && vid_req;
  assign w_pop      = !reset && (r_state == ST_RUN) && !vid_req && !w_wq_empty;
  // A push into a full queue is still accepted when the head leaves this cycle
  assign w_push     = cpu_wr && (!w_wq_full || w_pop);

  assign cpu_busy   = w_wq_full;
  assign wr_drop    = r_wr_drop;
  assign init_done  = (r_state == ST_RUN);
  assign vid_valid  = r_vid_valid;
  assign vid_color  = r_vid_color;
  assign ram_oce    = 1'b1;
  assign ram_reset  = reset;

  // FSM state and init counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Next-state logic and RAM port drive
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    ram_ce         = 1'b0;
    ram_wre        = 1'b0;
    ram_ad         = '0;
    ram_din        = '0;
    if (!reset) begin
      case (r_state)
        ST_INIT: begin
          ram_ce         = 1'b1;
          ram_wre        = 1'b1;
          ram_ad         = r_init_cnt;
          ram_din        = {r_init_cnt, r_init_cnt};
          w_init_cnt_nxt = r_init_cnt + 4'd1;
          if (r_init_cnt == c_last) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_rd_issue) begin
            ram_ce = 1'b1;
            ram_ad = vid_idx;
          end else if (w_pop) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = w_wq_head[11:8];
            ram_din = w_wq_head[7:0];
          end
        end
        default: begin
          w_state_nxt = ST_INIT;
        end
      endcase
    end
  end

  // Queue pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wq_rd_ptr <= '0;
      r_wq_wr_ptr <= '0;
      r_wq_count  <= '0;
      r_wr_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wq_wr_ptr <= r_wq_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_wq_rd_ptr <= r_wq_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_wq_count <= r_wq_count + 1'b1;
        2'b01:   r_wq_count <= r_wq_count - 1'b1;
        default: r_wq_count <= r_wq_count;
      endcase
      if (cpu_wr && !w_push) begin
        r_wr_drop <= 1'b1;
      end
    end
  end

  // Queue storage; the head is read combinationally before any overwrite lands
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wq_mem[r_wq_wr_ptr] <= {cpu_idx, cpu_data};
    end
  end

  // Lookup pipeline: issue -> RAM output -> registered colour
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_p1     <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_color <= '0;
    end else begin
      r_rd_p1     <= w_rd_issue;
      r_vid_valid <= r_rd_p1;
      if (r_rd_p1) begin
        r_vid_color <= ram_dout;
      end
    end
  end

endmodule
`default_nettype wire
